// File: rtl/controller_if.sv
// APB-side bus of the SPI flash controller.
// The master drives the access and the slave returns the last word read from flash.
interface controller_if #(
  parameter int APB_WIDTH = 32
);
  logic [APB_WIDTH-1:0] p_addr;
  logic                 p_write;
  logic                 p_sel_x;
  logic                 p_enable;
  logic [APB_WIDTH-1:0] p_wdata;
  logic [APB_WIDTH-1:0] p_rdata;

  modport master (
    output p_addr, p_write, p_sel_x, p_enable, p_wdata,
    input  p_rdata
  );

  modport slave (
    input  p_addr, p_write, p_sel_x, p_enable, p_wdata,
    output p_rdata
  );
endinterface

// File: rtl/controller.sv
// APB to parallel-SPI flash bridge.
//
// Each accepted APB access becomes one 8-beat frame:
//   opcode, addr[23:16], addr[15:8], addr[7:0], data[31:24] .. data[7:0].
// Each beat is two p_clk cycles, with the low phase first and then the high phase.
// In a read frame, s_miso is sampled at the end of the high phase of beats 4-7.
// While a frame is in flight, APB accesses are dropped.
//
// Optional macro WREN_CMD_EN: a write is preceded by a one-beat CMD_WREN frame.
// That frame is followed by one cycle with chip select high.
//
// state      | meaning
// IDLE       | waiting for p_sel_x & p_enable; s_css high
// SHIFT      | main frame, beat_q/phase_q select byte and clock level
// END        | one cycle with s_css high after the last beat
// WREN_BEAT  | (WREN_CMD_EN) single write-enable beat
// WREN_GAP   | (WREN_CMD_EN) one cycle with s_css high before the write frame
module controller #(
  parameter int                   APB_WIDTH = 32,
  parameter int                   SPI_WIDTH = 8,
  parameter logic [SPI_WIDTH-1:0] CMD_WRITE = 8'h02,
  parameter logic [SPI_WIDTH-1:0] CMD_READ  = 8'h01,
  parameter logic [SPI_WIDTH-1:0] CMD_WREN  = 8'h06
) (
  input  logic                 p_clk,
  input  logic                 p_reset_n,
  controller_if.slave          apb,
  output logic [SPI_WIDTH-1:0] s_mosi,
  input  logic [SPI_WIDTH-1:0] s_miso,
  output logic                 s_clk,
  output logic                 s_css
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT     = 3'd1,
    END       = 3'd2,
    WREN_BEAT = 3'd3,
    WREN_GAP  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [2:0]  beat_q, beat_d;
  logic        phase_q, phase_d;
  logic        accept;

  logic        wr_q;
  logic [23:0] addr_q;
  logic [31:0] wdata_q;
  logic [23:0] rx_q;
  logic [31:0] rdata_q;
  logic [SPI_WIDTH-1:0] beat_byte;

  // Only the low 24 address bits reach the flash.
  logic unused_addr_hi;
  assign unused_addr_hi = ^apb.p_addr[APB_WIDTH-1:24];

  assign accept      = (state_q == IDLE) && apb.p_sel_x && apb.p_enable;
  assign apb.p_rdata = rdata_q;

  // State, beat and phase registers.
  always_ff @(posedge p_clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      state_q <= IDLE;
      beat_q  <= 3'd0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      phase_q <= phase_d;
    end
  end

  // Byte presented on s_mosi for the current beat of the main frame.
  always_comb begin
    beat_byte = '0;
    case (beat_q)
      3'd0: beat_byte = wr_q ? CMD_WRITE : CMD_READ;
      3'd1: beat_byte = addr_q[23:16];
      3'd2: beat_byte = addr_q[15:8];
      3'd3: beat_byte = addr_q[7:0];
      3'd4: beat_byte = wr_q ? wdata_q[31:24] : '0;
      3'd5: beat_byte = wr_q ? wdata_q[23:16] : '0;
      3'd6: beat_byte = wr_q ? wdata_q[15:8]  : '0;
      3'd7: beat_byte = wr_q ? wdata_q[7:0]   : '0;
      default: beat_byte = '0;
    endcase
  end

  // Next-state logic and SPI pin decode.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    phase_d = phase_q;
    s_css   = 1'b1;
    s_clk   = 1'b0;
    s_mosi  = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          beat_d  = 3'd0;
          phase_d = 1'b0;
`ifdef WREN_CMD_EN
          state_d = apb.p_write ? WREN_BEAT : SHIFT;
`else
          state_d = SHIFT;
`endif
        end
      end
`ifdef WREN_CMD_EN
      WREN_BEAT: begin
        s_css   = 1'b0;
        s_clk   = phase_q;
        s_mosi  = CMD_WREN;
        phase_d = ~phase_q;
        if (phase_q) state_d = WREN_GAP;
      end
      WREN_GAP: begin
        beat_d  = 3'd0;
        phase_d = 1'b0;
        state_d = SHIFT;
      end
`endif
      SHIFT: begin
        s_css   = 1'b0;
        s_clk   = phase_q;
        s_mosi  = beat_byte;
        phase_d = ~phase_q;
        if (phase_q) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) state_d = END;
        end
      end
      END:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the access on acceptance and assemble read data MSB first.
  // p_rdata updates on the same edge that moves SHIFT to END.
  always_ff @(posedge p_clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      wr_q    <= 1'b0;
      addr_q  <= 24'd0;
      wdata_q <= 32'd0;
      rx_q    <= 24'd0;
      rdata_q <= 32'd0;
    end else begin
      if (accept) begin
        wr_q    <= apb.p_write;
        addr_q  <= apb.p_addr[23:0];
        wdata_q <= apb.p_wdata[31:0];
      end
      if (state_q == SHIFT && phase_q && beat_q[2]) begin
        rx_q <= {rx_q[15:0], s_miso};
        if (beat_q == 3'd7 && !wr_q) rdata_q <= {rx_q, s_miso};
      end
    end
  end

endmodule

// File: tb/tb_controller.sv
// Directed bench for the APB to SPI flash controller.
// Expected SPI bytes are queued as each access is issued.
// They are popped in every low phase that has s_css low.
module tb_controller;

  logic       p_clk;
  logic       p_reset_n;
  logic [7:0] s_mosi;
  logic [7:0] s_miso;
  logic       s_clk;
  logic       s_css;

  controller_if #(.APB_WIDTH(32)) apb ();

  controller dut (
    .p_clk     (p_clk),
    .p_reset_n (p_reset_n),
    .apb       (apb),
    .s_mosi    (s_mosi),
    .s_miso    (s_miso),
    .s_clk     (s_clk),
    .s_css     (s_css)
  );

  initial p_clk = 1'b0;
  always #5 p_clk = ~p_clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] exp_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one access starting at a negedge and returns at a negedge.
  // inject_at: cycle for a stray APB access. abort_at: cycle for a reset pulse (0 = none).
  task automatic frame(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] miso, input int inject_at, input int abort_at);
    int   ncyc;
    int   css_low;
    int   exp_low;
    int   beat;
    bit   aborted;
    logic [7:0] last;
    logic [31:0] dbytes;
    ncyc    = 20;
    exp_low = 16;
    css_low = 0;
    beat    = 0;
    aborted = 0;
    last    = 8'h00;
    dbytes  = wr ? wdata : 32'h0;
`ifdef WREN_CMD_EN
    if (wr) begin
      exp_q.push_back(8'h06);
      ncyc    = 23;
      exp_low = 18;
    end
`endif
    exp_q.push_back(wr ? 8'h02 : 8'h01);
    exp_q.push_back(addr[23:16]);
    exp_q.push_back(addr[15:8]);
    exp_q.push_back(addr[7:0]);
    exp_q.push_back(dbytes[31:24]);
    exp_q.push_back(dbytes[23:16]);
    exp_q.push_back(dbytes[15:8]);
    exp_q.push_back(dbytes[7:0]);
    if (!wr) exp_rdata = miso;

    apb.p_write  = wr;
    apb.p_addr   = addr;
    apb.p_wdata  = wdata;
    apb.p_sel_x  = 1'b1;
    apb.p_enable = 1'b1;
    @(negedge p_clk);
    apb.p_sel_x  = 1'b0;
    apb.p_enable = 1'b0;

    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      if (abort_at == cyc) begin
        p_reset_n = 1'b0;
        #1;
        check("abort_css", s_css, 1'b1);
        check("abort_sclk", s_clk, 1'b0);
        check("abort_mosi", s_mosi, 8'h00);
        check("abort_rdata", apb.p_rdata, 32'h0);
        exp_rdata = 32'h0;
        exp_q.delete();
        @(negedge p_clk);
        p_reset_n = 1'b1;
        aborted = 1;
        break;
      end
      if (s_css === 1'b0) begin
        css_low++;
        if (s_clk === 1'b0) begin
          if (exp_q.size() == 0) begin
            check("extra_beat", s_mosi, 8'hxx);
          end else begin
            last = exp_q.pop_front();
            check("mosi_low", s_mosi, last);
          end
          s_miso = (beat >= 4 && beat <= 7) ? miso[8*(7-beat) +: 8] : 8'h5A;
          beat++;
        end else begin
          check("mosi_held", s_mosi, last);
        end
      end else begin
        beat = 0;
        check("sclk_idle", s_clk, 1'b0);
      end
      if (inject_at == cyc) begin
        apb.p_write  = ~wr;
        apb.p_addr   = 32'h00ABCDEF;
        apb.p_wdata  = 32'hDEADBEEF;
        apb.p_sel_x  = 1'b1;
        apb.p_enable = 1'b1;
      end else begin
        apb.p_sel_x  = 1'b0;
        apb.p_enable = 1'b0;
      end
      @(negedge p_clk);
    end

    if (!aborted) begin
      check("css_low_cycles", css_low, exp_low);
      check("beats_left", exp_q.size(), 0);
      check("rdata", apb.p_rdata, exp_rdata);
      check("end_css", s_css, 1'b1);
      check("end_mosi", s_mosi, 8'h00);
    end
  endtask

  initial begin
    p_reset_n    = 1'b0;
    s_miso       = 8'h00;
    apb.p_addr   = 32'h0;
    apb.p_write  = 1'b0;
    apb.p_sel_x  = 1'b0;
    apb.p_enable = 1'b0;
    apb.p_wdata  = 32'h0;
    exp_rdata    = 32'h0;

    #12;
    check("rst_css", s_css, 1'b1);
    check("rst_sclk", s_clk, 1'b0);
    check("rst_mosi", s_mosi, 8'h00);
    check("rst_rdata", apb.p_rdata, 32'h0);

    @(negedge p_clk);
    p_reset_n = 1'b1;

    // Select without enable must never start a frame.
    for (int i = 0; i < 6; i++) begin
      apb.p_sel_x  = 1'b1;
      apb.p_enable = 1'b0;
      @(negedge p_clk);
      check("idle_css", s_css, 1'b1);
      check("idle_sclk", s_clk, 1'b0);
    end
    apb.p_sel_x = 1'b0;
    @(negedge p_clk);

    frame(1'b1, 32'h00000000, 32'hFF00FF00, 32'h0, 0, 0);
    frame(1'b0, 32'h00123456, 32'h0, 32'hAABBCCDD, 0, 0);
    frame(1'b1, 32'hFF000100, 32'h12345678, 32'h0, 5, 0);
    frame(1'b0, 32'h00FEDCBA, 32'h0, 32'h01020304, 0, 0);
    frame(1'b0, 32'h00654321, 32'h0, 32'h99887766, 0, 11);
    frame(1'b0, 32'h00000042, 32'h0, 32'h11223344, 0, 0);
    frame(1'b1, 32'h00FFFFFF, 32'hA5A5C3C3, 32'h0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 Parameter APB_WIDTH, default 32: APB address and data width.
REQ-002 Parameter SPI_WIDTH, default 8: SPI beat width; every s_clk beat carries one parallel byte.
REQ-003 Parameter CMD_WRITE, default 8'h02: flash program opcode.
REQ-004 Parameter CMD_READ, default 8'h01: flash read opcode.
REQ-005 Parameter CMD_WREN, default 8'h06: write-enable opcode, used only under WREN_CMD_EN.
REQ-006 p_clk  input  1: single clock; all logic SHALL be rising-edge triggered.
REQ-007 p_reset_n  input  1: reset, asynchronous and active-low.
REQ-008 p_addr  input  32: APB address; bits [23:0] SHALL form the flash address.
REQ-009 p_write  input  1: 1 = write access, 0 = read access.
REQ-010 p_sel_x  input  1: APB slave select.
REQ-011 p_enable  input  1: APB access phase.
REQ-012 p_wdata  input  32: APB write data.
REQ-013 p_rdata  output  32: last word read from flash.
REQ-014 s_mosi  output  8: SPI byte to flash.
REQ-015 s_miso  input  8: SPI byte from flash.
REQ-016 s_clk  output  1: SPI clock, idle low.
REQ-017 s_css  output  1: SPI chip select, active-low, idle high.

Function
REQ-018 Start condition: the FSM SHALL accept an access on the p_clk edge where it is IDLE and p_sel_x=1 and p_enable=1.
REQ-019 On acceptance, the FSM SHALL latch p_write, p_addr[23:0] and p_wdata.
REQ-020 While the FSM is not IDLE, APB accesses SHALL be ignored; there is no wait-state signalling.
REQ-021 The FSM SHALL have the states IDLE, SHIFT and END.
REQ-022 Transitions: IDLE->SHIFT on acceptance; SHIFT->END after beat 7; END->IDLE after one cycle.
REQ-023 A frame SHALL consist of 8 beats, in this order:
  - beat 0: opcode (CMD_WRITE if the latched p_write=1, else CMD_READ);
  - beats 1-3: address[23:16], [15:8], [7:0];
  - beats 4-7: data[31:24], [23:16], [15:8], [7:0].
REQ-024 Each beat SHALL last exactly 2 p_clk cycles: low phase first, then high phase.
REQ-025 Low phase: s_clk=0 and s_mosi = the beat byte. High phase: s_clk=1 and s_mosi held.
REQ-026 s_css SHALL be 0 throughout SHIFT, going low in the first cycle after acceptance, and 1 in IDLE and END.
REQ-027 A frame SHALL hold s_css low for exactly 16 cycles.
REQ-028 A frame SHALL occupy 18 cycles from acceptance back to IDLE.
REQ-029 Read sampling: s_miso SHALL be captured on the p_clk edge that ends the high phase of each of beats 4-7, assembled MSB first.
REQ-030 Write frames: s_mosi in beats 4-7 SHALL carry the latched p_wdata, MSB first.
REQ-031 Read frames: s_mosi in beats 4-7 SHALL be 8'h00.
REQ-032 p_rdata SHALL update with the assembled word on entry to END, and only for read frames.
REQ-033 p_rdata SHALL otherwise hold its value.
REQ-034 In IDLE, s_mosi SHALL be 8'h00.

Reset
REQ-035 Asserting p_reset_n=0 SHALL immediately force IDLE, with s_css=1, s_clk=0, s_mosi=0 and p_rdata=0, aborting any frame in progress.
REQ-036 No partial p_rdata update SHALL occur on abort.
REQ-037 After p_reset_n rises, the first access SHALL be accepted on the next qualifying edge.

Configuration
REQ-038 Macro WREN_CMD_EN.
  - Defined: each write access SHALL first issue a 1-beat frame carrying CMD_WREN (s_css low for 2 cycles), then hold s_css high for 1 cycle, then send the normal write frame.
  - Not defined: write frames SHALL be sent directly.
  - Read frames SHALL be unaffected in both cases.

Verification
REQ-039 Write p_addr=0x00000000, p_wdata=0xFF00FF00 -> s_mosi beats = 02,00,00,00,FF,00,FF,00; s_css low 16 cycles; p_rdata unchanged (0).
REQ-040 Read p_addr=0x00123456, with flash driving s_miso bytes AA,BB,CC,DD in beats 4-7 -> s_mosi = 01,12,34,56,00,00,00,00; p_rdata=0xAABBCCDD after END.
REQ-041 Second APB access issued 5 cycles into a frame -> ignored; exactly one frame seen; next access after IDLE accepted.
REQ-042 Assert p_reset_n=0 during beat 5 of a read -> s_css=1, s_clk=0 immediately; p_rdata=0.
REQ-043 With WREN_CMD_EN defined, write 0x12345678 -> frame 06 (2 cycles), s_css high 1 cycle, then 02,addr,12,34,56,78.
REQ-044 Idle check: p_sel_x=1, p_enable=0 held -> s_css stays 1 and s_clk stays 0.
